// File: rtl/freq_meter_core_if.sv
// Purpose : control/result bundle of the frequency meter (start/mode in, result out).
// Latency : n/a (wiring only).
// Backpressure: none; freq_valid is a one-cycle pulse with no ready, results are held.
//
// Ports (signals):
//   cont_en    - 1: back-to-back measurements, 0: single-shot
//   start      - one-cycle pulse that triggers a single-shot measurement
//   busy       - measurement in progress
//   freq       - last measured frequency in Hz
//   freq_valid - one-cycle pulse when freq is updated
//   ovf        - saturation / divide-by-zero in the last result
//   no_sig     - last measurement timed out waiting for the counters
interface freq_meter_core_if #(
    parameter int FREQ_W = 34
);
    logic              cont_en;
    logic              start;
    logic              busy;
    logic [FREQ_W-1:0] freq;
    logic              freq_valid;
    logic              ovf;
    logic              no_sig;

    modport master (
        output cont_en, start,
        input  busy, freq, freq_valid, ovf, no_sig
    );

    modport slave (
        input  cont_en, start,
        output busy, freq, freq_valid, ovf, no_sig
    );
endinterface

// File: rtl/freq_meter_core.sv
// Purpose : reciprocal-gate frequency meter; freq = floor(STAND_FREQ * n_test / n_stand).
// Latency : GATE_CYC + CDC (~2 clk_test + ~2 clk_stand + 3 sys_clk) + FREQ_W divide + 1 cycles.
// Backpressure: none; start is ignored while busy, results are held until the next freq_valid.
//
// Ports:
//   sys_clk   - system clock (FSM, cap synchronisers, divider)
//   sys_rst_n - asynchronous active-low reset for every clock domain
//   clk_stand - reference clock, frequency STAND_FREQ
//   clk_test  - clock under measurement
//   bus       - freq_meter_core_if.slave: cont_en/start in, busy/freq/freq_valid/ovf/no_sig out
// Optional feature: define FREQ_METER_TIMEOUT_EN to enable the no-signal watchdog in WAIT_CAP.
module freq_meter_core #(
    parameter int CNT_W       = 32,
    parameter int FREQ_W      = 34,
    parameter int STAND_FREQ  = 60_000_000,
    parameter int GATE_CYC    = 24_000_000,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_stand,
    input  logic             clk_test,
    freq_meter_core_if.slave bus
);
    localparam int SF_W  = $clog2(STAND_FREQ + 1);
    // Numerator holds STAND_FREQ * n_test without truncation, even for narrow counters.
    localparam int NUM_W = (2 * CNT_W > CNT_W + SF_W) ? 2 * CNT_W : CNT_W + SF_W;
    localparam int GC_W  = $clog2(GATE_CYC);
    localparam int DC_W  = $clog2(FREQ_W);

    typedef enum logic [2:0] {IDLE, GATE, WAIT_CAP, DIV, DONE} state_t;

    state_t state, nxt;

    logic              gate_s;
    logic [GC_W-1:0]   gate_cnt;
    logic              busy_q, freq_valid_q, ovf_q;
    logic [FREQ_W-1:0] freq_q;

    // ---------------- clk_test domain ----------------
    logic             t_g1, gate_a, t_gp;
    logic [CNT_W-1:0] t_cnt, t_hold;
    logic             t_sat, t_hold_sat, t_cap;

    always_ff @(posedge clk_test or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            t_g1       <= 1'b0;
            gate_a     <= 1'b0;
            t_gp       <= 1'b0;
            t_cnt      <= '0;
            t_sat      <= 1'b0;
            t_hold     <= '0;
            t_hold_sat <= 1'b0;
            t_cap      <= 1'b0;
        end else begin
            t_g1   <= gate_s;
            gate_a <= t_g1;
            t_gp   <= gate_a;
            // The edge that reveals the rise is itself inside the gate, so it counts as 1.
            if (gate_a && !t_gp) begin
                t_cnt <= CNT_W'(1);
                t_sat <= 1'b0;
            end else if (gate_a) begin
                if (&t_cnt) t_sat <= 1'b1;
                else        t_cnt <= t_cnt + 1'b1;
            end
            if (!gate_a && t_gp) begin
                t_hold     <= t_cnt;
                t_hold_sat <= t_sat;
                t_cap      <= ~t_cap;
            end
        end
    end

    // ---------------- clk_stand domain ----------------
    // Gated by gate_a (not gate_s) so both windows share clk_test edge boundaries.
    logic             s_g1, gate_b, s_gp;
    logic [CNT_W-1:0] s_cnt, s_hold;
    logic             s_sat, s_hold_sat, s_cap;

    always_ff @(posedge clk_stand or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s_g1       <= 1'b0;
            gate_b     <= 1'b0;
            s_gp       <= 1'b0;
            s_cnt      <= '0;
            s_sat      <= 1'b0;
            s_hold     <= '0;
            s_hold_sat <= 1'b0;
            s_cap      <= 1'b0;
        end else begin
            s_g1   <= gate_a;
            gate_b <= s_g1;
            s_gp   <= gate_b;
            if (gate_b && !s_gp) begin
                s_cnt <= CNT_W'(1);
                s_sat <= 1'b0;
            end else if (gate_b) begin
                if (&s_cnt) s_sat <= 1'b1;
                else        s_cnt <= s_cnt + 1'b1;
            end
            if (!gate_b && s_gp) begin
                s_hold     <= s_cnt;
                s_hold_sat <= s_sat;
                s_cap      <= ~s_cap;
            end
        end
    end

    // ---------------- cap flag synchronisers (sys_clk) ----------------
    logic tc1, tc2, tc3, sc1, sc2, sc3;
    logic tog_t, tog_s, seen_t, seen_s, caps_done;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            {tc1, tc2, tc3} <= 3'b000;
            {sc1, sc2, sc3} <= 3'b000;
            seen_t          <= 1'b0;
            seen_s          <= 1'b0;
        end else begin
            tc1 <= t_cap;
            tc2 <= tc1;
            tc3 <= tc2;
            sc1 <= s_cap;
            sc2 <= sc1;
            sc3 <= sc2;
            // Toggles are only honoured in WAIT_CAP; late ones (after a timeout) fall away.
            seen_t <= (state == WAIT_CAP) ? (seen_t | tog_t) : 1'b0;
            seen_s <= (state == WAIT_CAP) ? (seen_s | tog_s) : 1'b0;
        end
    end

    assign tog_t     = tc2 ^ tc3;
    assign tog_s     = sc2 ^ sc3;
    assign caps_done = (seen_t | tog_t) & (seen_s | tog_s);

    // ---------------- watchdog ----------------
    logic wd_exp;
`ifdef FREQ_METER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            no_sig_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wd_cnt   <= '0;
            no_sig_q <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT_CAP) ? wd_cnt + 1'b1 : '0;
            if (nxt == DONE) no_sig_q <= (state == WAIT_CAP);
        end
    end

    assign wd_exp      = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign bus.no_sig  = no_sig_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign wd_exp      = 1'b0;
    assign bus.no_sig  = 1'b0;
`endif

    // ---------------- FSM ----------------
    logic [DC_W-1:0] div_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (bus.start || bus.cont_en) nxt = GATE;
            GATE:     if (gate_cnt == GC_W'(GATE_CYC - 1)) nxt = WAIT_CAP;
            WAIT_CAP: begin
                if (caps_done)   nxt = DIV;
                else if (wd_exp) nxt = DONE;
            end
            DIV:      if (div_cnt == DC_W'(FREQ_W - 1)) nxt = DONE;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // ---------------- restoring divider ----------------
    // The first DIV cycle seeds itself straight from the hold registers: the partial
    // remainder starts as num >> FREQ_W and the low FREQ_W numerator bits are shifted in,
    // one quotient bit per cycle. num >> FREQ_W >= den means the quotient will not fit.
    logic [NUM_W-1:0]  num, num_hi;
    logic [CNT_W-1:0]  rem, rem_src, rem_nxt;
    logic [FREQ_W-1:0] sh, sh_src, sh_nxt;
    logic [CNT_W:0]    trial;
    logic              first, q_bit, q_ovf, q_ovf_src;

    assign num       = NUM_W'(STAND_FREQ) * NUM_W'(t_hold);
    assign num_hi    = num >> FREQ_W;
    assign first     = (div_cnt == '0);
    assign rem_src   = first ? CNT_W'(num_hi) : rem;
    assign sh_src    = first ? FREQ_W'(num) : sh;
    assign q_ovf_src = first ? (num_hi >= NUM_W'(s_hold)) : q_ovf;
    assign trial     = {rem_src, sh_src[FREQ_W-1]};
    assign q_bit     = (trial >= {1'b0, s_hold});
    assign rem_nxt   = q_bit ? CNT_W'(trial - {1'b0, s_hold}) : trial[CNT_W-1:0];
    assign sh_nxt    = {sh_src[FREQ_W-2:0], q_bit};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt <= '0;
            rem     <= '0;
            sh      <= '0;
            q_ovf   <= 1'b0;
        end else if (state == DIV) begin
            div_cnt <= div_cnt + 1'b1;
            rem     <= rem_nxt;
            sh      <= sh_nxt;
            q_ovf   <= q_ovf_src;
        end else begin
            div_cnt <= '0;
        end
    end

    // ---------------- gate timer and outputs ----------------
    // Results load on the edge entering DONE, so freq_valid and the new freq coincide.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gate_cnt     <= '0;
            gate_s       <= 1'b0;
            busy_q       <= 1'b0;
            freq_valid_q <= 1'b0;
            freq_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            gate_cnt     <= (state == GATE) ? gate_cnt + 1'b1 : '0;
            gate_s       <= (nxt == GATE);
            busy_q       <= (nxt != IDLE);
            freq_valid_q <= (nxt == DONE);
            if (state == DIV && nxt == DONE) begin
                if (s_hold == '0)   freq_q <= '0;
                else if (q_ovf_src) freq_q <= '1;
                else                freq_q <= sh_nxt;
                ovf_q <= (s_hold == '0) | q_ovf_src | t_hold_sat | s_hold_sat;
            end else if (state == WAIT_CAP && nxt == DONE) begin
                freq_q <= '0;
                ovf_q  <= 1'b0;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.freq       = freq_q;
    assign bus.freq_valid = freq_valid_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_freq_meter_core.sv
// Purpose : randomized self-checking bench for freq_meter_core against an ideal-ratio model.
// Latency : each measurement ~GATE_CYC sys_clk cycles.
// Backpressure: n/a.
`timescale 1ps/1ps
module tb_freq_meter_core;
    localparam int  GATE_CYC    = 6000;
    localparam int  TIMEOUT_CYC = 1000;
    localparam int  STAND_FREQ  = 60_000_000;
    localparam int  P_SYS       = 20000;   // 50 MHz
    localparam int  P_STAND     = 16666;   // ~60 MHz
    localparam int  FREQ_W      = 34;

    logic sys_clk, sys_rst_n, clk_stand, clk_test;
    int   t_half = 50000;
    bit   t_run  = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid0 = 0;
    int n_valid1 = 0;

    freq_meter_core_if #(.FREQ_W(FREQ_W)) bus0 ();
    freq_meter_core_if #(.FREQ_W(FREQ_W)) bus1 ();

    freq_meter_core #(
        .CNT_W(32), .FREQ_W(FREQ_W), .STAND_FREQ(STAND_FREQ),
        .GATE_CYC(GATE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_stand(clk_stand),
        .clk_test(clk_test), .bus(bus0)
    );

    freq_meter_core #(
        .CNT_W(8), .FREQ_W(FREQ_W), .STAND_FREQ(STAND_FREQ),
        .GATE_CYC(GATE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_stand(clk_stand),
        .clk_test(clk_test), .bus(bus1)
    );

    initial begin
        sys_clk = 1'b0;
        forever #(P_SYS / 2) sys_clk = ~sys_clk;
    end

    initial begin
        clk_stand = 1'b0;
        forever #(P_STAND / 2) clk_stand = ~clk_stand;
    end

    initial begin
        clk_test = 1'b0;
        forever begin
            if (t_run) begin
                #(t_half) clk_test = ~clk_test;
            end else begin
                clk_test = 1'b0;
                #1000;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (bus0.freq_valid) n_valid0++;
        if (bus1.freq_valid) n_valid1++;
    end

    initial begin
        #(64'd1_900_000_000);
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit also1);
        bus0.start = 1'b1;
        bus1.start = also1;
        @(posedge sys_clk);
        #1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget && !ok) begin
            @(negedge sys_clk);
            cyc++;
            if (bus0.freq_valid) ok = 1'b1;
        end
    endtask

    // Ideal result is the true frequency ratio scaled by STAND_FREQ; one reference count of
    // quantisation over the gate window bounds the error.
    task automatic check_freq(input string tag, input int half);
        real    exp_r, tol_r;
        longint exp_i, tol_i, diff, obs;
        exp_r = real'(STAND_FREQ) * real'(P_STAND) / (2.0 * real'(half));
        tol_r = 1.2 * exp_r * real'(P_STAND) / (real'(GATE_CYC) * real'(P_SYS));
        exp_i = longint'(exp_r);
        tol_i = longint'(tol_r) + 2;
        obs   = longint'(bus0.freq);
        diff  = (obs > exp_i) ? obs - exp_i : exp_i - obs;
        check({tag, "_freq"}, (diff <= tol_i) ? exp_i : obs, exp_i);
        check({tag, "_ovf"}, longint'(bus0.ovf), 0);
        check({tag, "_nosig"}, longint'(bus0.no_sig), 0);
    endtask

    task automatic measure_single(input string tag, input int half);
        int cyc;
        bit ok;
        int base;
        t_half = half;
        repeat (20) @(negedge sys_clk);
        base = n_valid0;
        pulse_start(1'b0);
        check({tag, "_busy"}, longint'(bus0.busy), 1);
        wait_valid(GATE_CYC + 2000, cyc, ok);
        check({tag, "_done"}, longint'(ok), 1);
        if (ok) check_freq(tag, half);
        repeat (20) @(negedge sys_clk);
        check({tag, "_nvalid"}, longint'(n_valid0 - base), 1);
        check({tag, "_idle"}, longint'(bus0.busy), 0);
    endtask

    initial begin
        int cyc, base, low, half;
        bit ok;

        bus0.start = 1'b0; bus0.cont_en = 1'b0;
        bus1.start = 1'b0; bus1.cont_en = 1'b0;
        sys_rst_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("rst_busy",  longint'(bus0.busy), 0);
        check("rst_freq",  longint'(bus0.freq), 0);
        check("rst_valid", longint'(bus0.freq_valid), 0);
        check("rst_ovf",   longint'(bus0.ovf), 0);
        check("rst_nosig", longint'(bus0.no_sig), 0);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);

        // 10 MHz single shot on both instances; the 8-bit one saturates both counters.
        t_half = 50000;
        repeat (20) @(negedge sys_clk);
        base = n_valid0;
        pulse_start(1'b1);
        check("t10m_busy", longint'(bus0.busy), 1);
        wait_valid(GATE_CYC + 2000, cyc, ok);
        check("t10m_done", longint'(ok), 1);
        if (ok) check_freq("t10m", 50000);
        repeat (20) @(negedge sys_clk);
        check("t10m_nvalid", longint'(n_valid0 - base), 1);
        check("sat_nvalid",  longint'(n_valid1), 1);
        check("sat_freq",    longint'(bus1.freq), 60_000_000);
        check("sat_ovf",     longint'(bus1.ovf), 1);

        // start pulses while busy must be ignored
        half = $urandom_range(15000, 100000);
        t_half = half;
        repeat (20) @(negedge sys_clk);
        base = n_valid0;
        pulse_start(1'b0);
        repeat ($urandom_range(10, 2500)) @(negedge sys_clk);
        pulse_start(1'b0);
        repeat ($urandom_range(10, 2500)) @(negedge sys_clk);
        pulse_start(1'b0);
        wait_valid(GATE_CYC + 2000, cyc, ok);
        check("busy_start_done", longint'(ok), 1);
        if (ok) check_freq("busy_start", half);
        repeat (50) @(negedge sys_clk);
        check("busy_start_nvalid", longint'(n_valid0 - base), 1);
        check("busy_start_idle",   longint'(bus0.busy), 0);

        // continuous mode at 33.333 MHz, released during the third measurement
        t_half = 15000;
        repeat (20) @(negedge sys_clk);
        base = n_valid0;
        bus0.cont_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(GATE_CYC + 2000, cyc, ok);
            check($sformatf("cont%0d_done", k), longint'(ok), 1);
            if (ok) check_freq($sformatf("cont%0d", k), 15000);
            if (k < 2) begin
                low = 0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge sys_clk);
                    if (bus0.busy) break;
                    low++;
                end
                check($sformatf("cont%0d_gap_le1", k), longint'(low <= 1), 1);
            end
            if (k == 1) begin
                repeat (100) @(negedge sys_clk);
                bus0.cont_en = 1'b0;
            end
        end
        repeat (50) @(negedge sys_clk);
        check("cont_nvalid", longint'(n_valid0 - base), 3);
        check("cont_idle",   longint'(bus0.busy), 0);

        // reset in the middle of the gate aborts silently
        t_half = 50000;
        repeat (20) @(negedge sys_clk);
        base = n_valid0;
        pulse_start(1'b0);
        repeat ($urandom_range(100, 4000)) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1000;
        check("mid_rst_busy",  longint'(bus0.busy), 0);
        check("mid_rst_freq",  longint'(bus0.freq), 0);
        check("mid_rst_valid", longint'(bus0.freq_valid), 0);
        check("mid_rst_ovf",   longint'(bus0.ovf), 0);
        check("mid_rst_nosig", longint'(bus0.no_sig), 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (GATE_CYC + 300) @(negedge sys_clk);
        check("mid_rst_nvalid", longint'(n_valid0 - base), 0);
        check("mid_rst_idle",   longint'(bus0.busy), 0);
        check("mid_rst_freq2",  longint'(bus0.freq), 0);
        measure_single("post_rst", 50000);

        // random single-shot frequencies
        for (int k = 0; k < 2; k++) begin
            half = $urandom_range(15000, 100000);
            measure_single($sformatf("rnd%0d", k), half);
        end

`ifdef FREQ_METER_TIMEOUT_EN
        // dead test clock: watchdog ends the measurement TIMEOUT_CYC after WAIT_CAP
        t_run = 1'b0;
        repeat (20) @(negedge sys_clk);
        pulse_start(1'b0);
        wait_valid(GATE_CYC + TIMEOUT_CYC + 200, cyc, ok);
        check("to_done",  longint'(ok), 1);
        check("to_lat",   longint'(cyc), longint'(GATE_CYC + TIMEOUT_CYC + 1));
        check("to_freq",  longint'(bus0.freq), 0);
        check("to_nosig", longint'(bus0.no_sig), 1);
        check("to_ovf",   longint'(bus0.ovf), 0);
        t_run = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
